// File: rtl/img_rsz_pool_pkg.sv
// Shared definitions for the image resizer: default geometry, derived widths,
// pooling mode and FSM state encodings, and the datapath typedefs.
package img_rsz_pool_pkg;

  localparam int DEF_IMG_W_MAX = 1024;
  localparam int DEF_IMG_H_MAX = 1024;
  localparam int DEF_RSZ_W     = 32;
  localparam int DEF_RSZ_H     = 32;
  localparam int DEF_CH_NUM    = 3;
  localparam int DEF_CH_W      = 8;

  // The field width doubles as the largest legal log2 block size, so an
  // accumulator of CH_W + both widths can hold a full block sum.
  localparam int BLK_W_SZ_W = $clog2(DEF_IMG_W_MAX / DEF_RSZ_W);
  localparam int BLK_H_SZ_W = $clog2(DEF_IMG_H_MAX / DEF_RSZ_H);
  localparam int ACC_DEF_W  = DEF_CH_W + BLK_W_SZ_W + BLK_H_SZ_W;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

  typedef logic [ACC_DEF_W-1:0]             acc_t;
  typedef logic [DEF_CH_W-1:0]              chan_t;
  typedef logic [DEF_CH_NUM*DEF_CH_W-1:0]   pxl_t;

  function automatic int clamp_log2(input int val, input int max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/img_rsz_pool_ch.sv
// One colour channel: a line of block accumulators with sum/max update and
// the average-shift or max-truncate readout.
module img_rsz_pool_ch
  import img_rsz_pool_pkg::*;
#(
  parameter int CW = DEF_CH_W,
  parameter int SW = BLK_W_SZ_W + BLK_H_SZ_W,
  parameter int AW = CW + SW,
  parameter int N  = DEF_RSZ_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_all,
  input  logic                 mode,
  input  logic                 acc_en,
  input  logic [$clog2(N)-1:0] acc_idx,
  input  logic [CW-1:0]        din,
  input  logic                 clr_en,
  input  logic [$clog2(N)-1:0] clr_idx,
  input  logic [$clog2(N)-1:0] rd_idx,
  input  logic [SW-1:0]        sh,
  output logic [CW-1:0]        dout
);

  logic [AW-1:0] acc_reg [N];
  logic [AW-1:0] acc_cur;
  logic [AW-1:0] acc_next;
  logic [AW-1:0] acc_rd;

  assign acc_cur = acc_reg[acc_idx];
  assign acc_rd  = acc_reg[rd_idx];

  always_comb begin
    acc_next = acc_cur;
    if (pool_mode_e'(mode) == POOL_MAX) begin
      if (AW'(din) > acc_cur) acc_next = AW'(din);
    end else begin
      acc_next = acc_cur + AW'(din);
    end
  end

  assign dout = (pool_mode_e'(mode) == POOL_MAX) ? acc_rd[CW-1:0] : CW'(acc_rd >> sh);

  always_ff @(posedge clk) begin
    if (!rst_n || clr_all) begin
      for (int i = 0; i < N; i++) acc_reg[i] <= '0;
    end else begin
      if (acc_en) acc_reg[acc_idx] <= acc_next;
      if (clr_en) acc_reg[clr_idx] <= '0;
    end
  end

endmodule

// File: rtl/img_rsz_pool.sv
// Block-pooling image downscaler: accumulates one block-row of raster pixels,
// then streams RSZ_W pooled pixels out before taking the next block-row.
module img_rsz_pool
  import img_rsz_pool_pkg::*;
#(
  parameter int IMG_W_MAX = DEF_IMG_W_MAX,
  parameter int IMG_H_MAX = DEF_IMG_H_MAX,
  parameter int RSZ_W     = DEF_RSZ_W,
  parameter int RSZ_H     = DEF_RSZ_H,
  parameter int CH_NUM    = DEF_CH_NUM,
  parameter int CH_W      = DEF_CH_W
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cfg_mode,
  input  logic [$clog2(IMG_W_MAX/RSZ_W)-1:0]   cfg_bw_log2,
  input  logic [$clog2(IMG_H_MAX/RSZ_H)-1:0]   cfg_bh_log2,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  input  logic                                 pxl_vld,
  output logic                                 pxl_rdy,
  input  logic [CH_NUM*CH_W-1:0]               pxl_data,
  output logic                                 rsz_vld,
  input  logic                                 rsz_rdy,
  output logic [CH_NUM*CH_W-1:0]               rsz_data,
  output logic                                 rsz_last
);

  localparam int BW_W  = $clog2(IMG_W_MAX / RSZ_W);
  localparam int BH_W  = $clog2(IMG_H_MAX / RSZ_H);
  localparam int SW    = BW_W + BH_W;
  localparam int AW    = CH_W + SW;
  localparam int XW    = $clog2(IMG_W_MAX);
  localparam int OXW   = $clog2(RSZ_W);
  localparam int ROW_W = $clog2(RSZ_H);

  state_e                  state_reg, state_next;
  pool_mode_e              mode_reg;
  logic [BW_W-1:0]         bw_reg;
  logic [BH_W-1:0]         bh_reg;
  logic [XW-1:0]           x_reg;
  logic [BH_W-1:0]         y_reg;
  logic [ROW_W-1:0]        row_reg;
  logic [OXW-1:0]          ox_reg;
  logic                    vld_reg, last_reg, done_reg;
  logic [CH_NUM*CH_W-1:0]  data_reg;

  logic [XW-1:0]           x_last;
  logic [BH_W-1:0]         y_last;
  logic [SW-1:0]           sh;
  logic [OXW-1:0]          acc_idx, rd_idx;
  logic [CH_NUM*CH_W-1:0]  ch_out;
  logic pxl_hs, out_hs, x_end, y_end, row_end, ox_end, ox_pre_end, blk_end, out_end;
  logic acc_en, clr_all, clr_en;

  assign x_last     = XW'((RSZ_W << bw_reg) - 1);
  assign y_last     = BH_W'((32'd1 << bh_reg) - 32'd1);
  assign sh         = SW'(bw_reg) + SW'(bh_reg);
  assign acc_idx    = OXW'(x_reg >> bw_reg);
  // While a pixel is on the output, the datapath already looks one ahead so
  // the next pixel can load on the same edge as the handshake.
  assign rd_idx     = vld_reg ? OXW'(ox_reg + 1'b1) : ox_reg;

  assign pxl_hs     = pxl_vld && (state_reg == ST_ACCUM);
  assign out_hs     = vld_reg && rsz_rdy;
  assign x_end      = (x_reg == x_last);
  assign y_end      = (y_reg == y_last);
  assign row_end    = (row_reg == ROW_W'(RSZ_H - 1));
  assign ox_end     = (ox_reg == OXW'(RSZ_W - 1));
  assign ox_pre_end = (OXW'(ox_reg + 1'b1) == OXW'(RSZ_W - 1));
  assign blk_end    = pxl_hs && x_end && y_end;
  assign out_end    = out_hs && ox_end;

  assign done     = done_reg;
  assign rsz_vld  = vld_reg;
  assign rsz_data = data_reg;
  assign rsz_last = last_reg;

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != ST_IDLE);
    pxl_rdy    = 1'b0;
    acc_en     = 1'b0;
    clr_all    = 1'b0;
    clr_en     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        clr_all = start;
        if (start) state_next = ST_ACCUM;
      end
      ST_ACCUM: begin
        pxl_rdy = 1'b1;
        acc_en  = pxl_vld;
        if (blk_end) state_next = ST_EMIT;
      end
      ST_EMIT: begin
        clr_en = out_hs;
        if (out_end) state_next = row_end ? ST_IDLE : ST_ACCUM;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      mode_reg  <= POOL_AVG;
      bw_reg    <= '0;
      bh_reg    <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      row_reg   <= '0;
      ox_reg    <= '0;
      vld_reg   <= 1'b0;
      last_reg  <= 1'b0;
      done_reg  <= 1'b0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == ST_EMIT) && out_end && row_end;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            mode_reg <= pool_mode_e'(cfg_mode);
            bw_reg   <= BW_W'(clamp_log2(int'(cfg_bw_log2), BW_W));
            bh_reg   <= BH_W'(clamp_log2(int'(cfg_bh_log2), BH_W));
            x_reg    <= '0;
            y_reg    <= '0;
            row_reg  <= '0;
            ox_reg   <= '0;
          end
        end
        ST_ACCUM: begin
          if (pxl_hs) begin
            if (x_end) begin
              x_reg <= '0;
              y_reg <= y_end ? '0 : y_reg + 1'b1;
            end else begin
              x_reg <= x_reg + 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (!vld_reg) begin
            vld_reg  <= 1'b1;
            data_reg <= ch_out;
            last_reg <= ox_end && row_end;
          end else if (rsz_rdy) begin
            if (ox_end) begin
              vld_reg  <= 1'b0;
              last_reg <= 1'b0;
              ox_reg   <= '0;
              row_reg  <= row_reg + 1'b1;
            end else begin
              ox_reg   <= ox_reg + 1'b1;
              data_reg <= ch_out;
              last_reg <= ox_pre_end && row_end;
            end
          end
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      img_rsz_pool_ch #(
        .CW (CH_W),
        .SW (SW),
        .AW (AW),
        .N  (RSZ_W)
      ) u_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_all (clr_all),
        .mode    (mode_reg),
        .acc_en  (acc_en),
        .acc_idx (acc_idx),
        .din     (pxl_data[gi*CH_W +: CH_W]),
        .clr_en  (clr_en),
        .clr_idx (ox_reg),
        .rd_idx  (rd_idx),
        .sh      (sh),
        .dout    (ch_out[gi*CH_W +: CH_W])
      );
    end
  endgenerate

endmodule

// File: doc/img_rsz_pool.md
IMG_RSZ_POOL -- requirements
Module: img_rsz_pool

Interface
REQ-001 The block SHALL have parameter IMG_W_MAX, default 1024, meaning maximum source width in pixels (power of two).
REQ-002 The block SHALL have parameter IMG_H_MAX, default 1024, meaning maximum source height in pixels (power of two).
REQ-003 The block SHALL have parameters RSZ_W and RSZ_H, default 32 each, meaning resized image width and height (powers of two).
REQ-004 The block SHALL have parameter CH_NUM, default 3, meaning primary colours per pixel.
REQ-005 The block SHALL have parameter CH_W, default 8, meaning bits per colour.
REQ-006 The block SHALL have these ports:
- clk  in  1  clock; one clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- cfg_mode  in  1  0 = average pooling, 1 = max pooling
- cfg_bw_log2  in  BLK_W_SZ_W  log2 of block width
- cfg_bh_log2  in  BLK_H_SZ_W  log2 of block height
- start  in  1  one-cycle frame start pulse
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last output pixel
- pxl_vld  in  1  input pixel valid
- pxl_rdy  out  1  input pixel accepted when pxl_vld & pxl_rdy
- pxl_data  in  CH_NUM*CH_W  raster-order source pixel, channel 0 in LSBs
- rsz_vld  out  1  output pixel valid
- rsz_rdy  in  1  downstream ready
- rsz_data  out  CH_NUM*CH_W  resized pixel
- rsz_last  out  1  marks last resized pixel of frame

Function
REQ-007 The block SHALL be a three-state FSM: IDLE, ACCUM, EMIT.
REQ-008 In IDLE, start SHALL latch cfg_* into internal registers, clear the line accumulators, and enter ACCUM; cfg_* changes at any other time SHALL be ignored.
REQ-009 Source width SHALL be RSZ_W << bw, source height RSZ_H << bh; cfg values giving width > IMG_W_MAX or height > IMG_H_MAX SHALL be clamped to the maximum log2.
REQ-010 In ACCUM, pxl_rdy SHALL be 1; each accepted pixel SHALL update accumulator [x >> bw] per channel: sum += data (mode 0) or max(acc, data) (mode 1).
REQ-011 Accumulators SHALL be CH_W + BLK_W_SZ_W + BLK_H_SZ_W bits wide; sums SHALL never overflow.
REQ-012 After the last pixel of each block-row (2^bh source lines), the FSM SHALL enter EMIT in the next cycle with pxl_rdy = 0.
REQ-013 In EMIT, the block SHALL present RSZ_W pixels in order 0..RSZ_W-1; rsz_data SHALL be acc >> (bw+bh) (mode 0, truncating) or acc[CH_W-1:0] (mode 1).
REQ-014 rsz_data and rsz_last SHALL hold stable while rsz_vld & !rsz_rdy; advance only on rsz_vld & rsz_rdy.
REQ-015 Each emitted accumulator SHALL be cleared on its handshake.
REQ-016 After the final pixel of a block-row is handshaken, the FSM SHALL return to ACCUM, or, if it was the last block-row, pulse done for one cycle and go to IDLE.
REQ-017 rsz_last SHALL be 1 only on pixel (RSZ_W-1, RSZ_H-1).
REQ-018 start while busy SHALL be ignored.
REQ-019 bw = bh = 0 SHALL pass pixels through unchanged in both modes.
REQ-020 Latency from acceptance of the last pixel of a block-row to first rsz_vld SHALL be exactly 2 cycles.

Reset
REQ-021 Synchronous reset SHALL force state IDLE, busy = 0, done = 0, pxl_rdy = 0, rsz_vld = 0, rsz_last = 0, rsz_data = 0, all counters and accumulators = 0, including mid-frame.

Structure
REQ-022 IMG_W_MAX, IMG_H_MAX, RSZ_W, RSZ_H, CH_NUM, CH_W defaults, the derived widths BLK_W_SZ_W/BLK_H_SZ_W, the pooling-mode enum and accumulator/pixel typedefs SHALL live in the shared image-resizer package.
REQ-023 One sub-module img_rsz_pool_ch (per-channel accumulate/max/shift datapath) SHALL be instantiated CH_NUM times.

Verification
REQ-024 64x64 ramp, bw=bh=1, mode 0, rsz_rdy=1 -> 1024 outputs, each the floor-average of its 2x2 block, rsz_last on the 1024th, done one cycle later.
REQ-025 Same frame, mode 1 -> each output equals the block's bottom-right pixel value.
REQ-026 All-255 1024x1024, bw=bh=5, mode 0 -> all outputs 255, no overflow.
REQ-027 rsz_rdy toggled randomly at 50% -> output sequence identical to REQ-024, data stable while stalled.
REQ-028 rst_n low for 1 cycle mid-EMIT, then new start -> all outputs at reset values, second frame correct.
REQ-029 32x32 frame, bw=bh=0 -> output equals input pixel for pixel in both modes.
